me_mb_scheduler: RTL and testbench
==================================

# me_mb_scheduler

Frame-level scheduler for the integer motion-estimation engine. It walks every macroblock of a frame in raster order and launches one full-search ME pass per macroblock through the ME controller's `start`/`ready` handshake. It consumes the SAD stream produced during the snake-scan search and tracks the minimum-SAD candidate, masking candidates that fall outside the frame. It returns one motion vector per macroblock to the mode-decision stage through a valid/ready handshake.

## Interface
- MACRO_DIM, 16, macroblock edge in pixels
- SEARCH_DIM, 48, search-window edge in pixels; P = SEARCH_DIM-MACRO_DIM = 32 positions per axis, offsets -P/2..P/2-1
- FRAME_W_MB, 22, frame width in macroblocks (1..255)
- FRAME_H_MB, 18, frame height in macroblocks (1..255)
- SAD_W, 16, SAD width
- clk  in  1  clock
- rst_n  in  1  reset: asynchronous, active-low
- frame_start  in  1  pulse; begins a frame when idle
- frame_busy  out  1  high from frame acceptance until frame_done
- frame_done  out  1  one-cycle pulse after the last macroblock result is accepted
- me_start  out  1  launch pulse to the ME controller
- me_ready  in  1  ME controller idle
- sad_valid  in  1  one candidate SAD presented this cycle
- sad_in  in  SAD_W  candidate SAD
- result_valid  out  1  motion vector result available
- result_ready  in  1  consumer accepts the result
- mb_x, mb_y  out  8 each  macroblock coordinates of the current result
- mv_x, mv_y  out  6 each  signed best offset in pixels (two's complement)
- best_sad  out  SAD_W  SAD at (mv_x, mv_y)

## Operation
- States: IDLE, LAUNCH, COLLECT, RESULT, ADVANCE.
- IDLE:
  - frame_start=1 clears mb_x and mb_y, sets frame_busy, and moves to LAUNCH.
  - frame_start in any other state is ignored.
- LAUNCH:
  - Waits for me_ready=1. On that cycle it drives me_start=1 combinationally, clears the candidate counter cand (10 bits), sets best_sad to all-ones, sets mv to (0,0), and moves to COLLECT.
- COLLECT: each sad_valid increments cand. The candidate order matches the ME controller's snake scan:
  - column c = cand/P, row r = cand%P.
  - dx = c - P/2.
  - dy = r - P/2 for even c; dy = P/2-1 - r for odd c.
- Masking: a candidate is in-frame iff 0 <= mb_x*MACRO_DIM+dx <= (FRAME_W_MB-1)*MACRO_DIM, and likewise for y. Candidate (0,0) is always in-frame, so every result is defined.
- Update rule: an in-frame candidate with sad_in < best_sad (strict) replaces best_sad, mv_x and mv_y. On a tie, the earliest candidate in scan order wins.
- The P*P-th (1024th) sad_valid moves the block to RESULT. sad_valid outside COLLECT is ignored.
- RESULT:
  - result_valid=1, with all result outputs held stable.
  - The handshake completes on a clock edge with result_valid&result_ready, and the block moves to ADVANCE.
  - No me_start is issued while in RESULT.
- ADVANCE:
  - mb_x increments. At FRAME_W_MB-1, mb_x wraps to 0 and mb_y increments.
  - If the macroblock just accepted was (FRAME_W_MB-1, FRAME_H_MB-1), the block pulses frame_done, clears frame_busy, and returns to IDLE. Otherwise it moves to LAUNCH.
- Arithmetic: the position compare uses signed 10-bit values or wider, with no wrap.

## Timing
- Reset values: all outputs 0 except best_sad = all-ones. State is IDLE and counters are 0.
- Reset mid-operation returns the block to IDLE immediately. The in-flight macroblock is discarded and the ME controller is reset by the same rst_n.
- frame_start at edge t → LAUNCH at t+1, and me_start is asserted at t+1 if me_ready=1.
- Compare and update are registered on the edge that samples sad_valid. The 1024th sad_valid at edge t → result_valid=1 during t+1, and best_sad already includes that candidate.
- Handshake at edge t → ADVANCE during t+1, then LAUNCH during t+2 (me_start at t+2 if me_ready). frame_done is asserted during t+1 for the last macroblock.
- me_start is never high for two consecutive cycles.

## Test plan
- 1x1 frame (FRAME_W_MB=FRAME_H_MB=1), 1024 random SADs with (0,0) not minimal → result mv (0,0) with best_sad = SAD at (0,0), then frame_done, then IDLE.
- 3x3 frame, MB(1,1), all SAD=1000 except 37 at cand=163 (c=5, r=3) → mv (-11,12), best_sad 37.
- 3x3 frame, MB(1,1), all SAD=1000, with 50 at cand=10 and at cand=900 → mv (-16,-6), best_sad 50 (first wins).
- 3x3 frame, MB(0,0): SAD 5 at (-1,0), which is out of frame, and SAD 20 at (3,4), all others 1000 → mv (3,4), best_sad 20.
- Backpressure: hold result_ready=0 for 10 cycles → result_valid and outputs stable and no me_start; raise result_ready → mb_x=1 and me_start two cycles after the handshake.
- Assert rst_n=0 after 500 sad_valid → all outputs at reset values. Then run a full 2x2 frame → 4 results in raster order and exactly one frame_done.

Source files
------------

// File: rtl/me_mb_scheduler_if.sv
`default_nettype none
// ============================================================================
// Module   : me_mb_scheduler_if
// Brief    : Frame-control, ME-launch, SAD-stream and result bundle of the
//            macroblock scheduler.
// Revision : 1.0
// ============================================================================
interface me_mb_scheduler_if #(
    parameter int SAD_W = 16
);
    logic             frame_start;
    logic             frame_busy;
    logic             frame_done;
    logic             me_start;
    logic             me_ready;
    logic             sad_valid;
    logic [SAD_W-1:0] sad_in;
    logic             result_valid;
    logic             result_ready;
    logic [7:0]       mb_x;
    logic [7:0]       mb_y;
    logic [5:0]       mv_x;
    logic [5:0]       mv_y;
    logic [SAD_W-1:0] best_sad;

    modport master (
        input  frame_start, me_ready, sad_valid, sad_in, result_ready,
        output frame_busy, frame_done, me_start, result_valid,
               mb_x, mb_y, mv_x, mv_y, best_sad
    );

    modport slave (
        output frame_start, me_ready, sad_valid, sad_in, result_ready,
        input  frame_busy, frame_done, me_start, result_valid,
               mb_x, mb_y, mv_x, mv_y, best_sad
    );
endinterface
`default_nettype wire

// File: rtl/me_mb_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : me_mb_scheduler
// Brief    : Raster-order macroblock walker; launches one full-search ME pass
//            per macroblock and reduces its SAD stream to a best motion vector.
// Revision : 1.0
// ============================================================================
module me_mb_scheduler #(
    parameter int MACRO_DIM  = 16,
    parameter int SEARCH_DIM = 48,
    parameter int FRAME_W_MB = 22,
    parameter int FRAME_H_MB = 18,
    parameter int SAD_W      = 16
) (
    input  wire               clk,
    input  wire               rst_n,
    me_mb_scheduler_if.master bus_io
);
    localparam int P     = SEARCH_DIM - MACRO_DIM;
    localparam int HALF  = P / 2;
    localparam int NCAND = P * P;
    localparam int CW    = $clog2(NCAND);
    localparam int X_MAX = (FRAME_W_MB - 1) * MACRO_DIM;
    localparam int Y_MAX = (FRAME_H_MB - 1) * MACRO_DIM;

    localparam logic [7:0]    LAST_X    = 8'(FRAME_W_MB - 1);
    localparam logic [7:0]    LAST_Y    = 8'(FRAME_H_MB - 1);
    localparam logic [CW-1:0] LAST_CAND = CW'(NCAND - 1);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_LAUNCH  = 3'd1,
        S_COLLECT = 3'd2,
        S_RESULT  = 3'd3,
        S_ADVANCE = 3'd4
    } state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cand_q, cand_d;
    logic [SAD_W-1:0] best_q, best_d;
    logic [5:0]       mvx_q, mvx_d;
    logic [5:0]       mvy_q, mvy_d;
    logic [7:0]       mbx_q, mbx_d;
    logic [7:0]       mby_q, mby_d;
    logic             busy_q, busy_d;
    logic             launch;
    logic             done_pulse;

    int   col, row, dx, dy, pos_x, pos_y;
    logic in_frame;

    // Snake-scan decode of the candidate index into an offset, then the
    // absolute pixel position used for frame-edge masking.
    always_comb begin
        col      = int'(cand_q) / P;
        row      = int'(cand_q) % P;
        dx       = col - HALF;
        dy       = ((col % 2) == 0) ? (row - HALF) : (HALF - 1 - row);
        pos_x    = int'(mbx_q) * MACRO_DIM + dx;
        pos_y    = int'(mby_q) * MACRO_DIM + dy;
        in_frame = (pos_x >= 0) && (pos_x <= X_MAX) &&
                   (pos_y >= 0) && (pos_y <= Y_MAX);
    end

    always_comb begin
        state_d    = state_q;
        cand_d     = cand_q;
        best_d     = best_q;
        mvx_d      = mvx_q;
        mvy_d      = mvy_q;
        mbx_d      = mbx_q;
        mby_d      = mby_q;
        busy_d     = busy_q;
        launch     = 1'b0;
        done_pulse = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (bus_io.frame_start) begin
                    mbx_d   = 8'd0;
                    mby_d   = 8'd0;
                    busy_d  = 1'b1;
                    state_d = S_LAUNCH;
                end
            end
            S_LAUNCH: begin
                if (bus_io.me_ready) begin
                    launch  = 1'b1;
                    cand_d  = '0;
                    best_d  = '1;
                    mvx_d   = 6'd0;
                    mvy_d   = 6'd0;
                    state_d = S_COLLECT;
                end
            end
            S_COLLECT: begin
                if (bus_io.sad_valid) begin
                    cand_d = cand_q + CW'(1);
                    // Strict compare keeps the earliest candidate on ties.
                    if (in_frame && (bus_io.sad_in < best_q)) begin
                        best_d = bus_io.sad_in;
                        mvx_d  = 6'(dx);
                        mvy_d  = 6'(dy);
                    end
                    if (cand_q == LAST_CAND) begin
                        state_d = S_RESULT;
                    end
                end
            end
            S_RESULT: begin
                if (bus_io.result_ready) begin
                    state_d = S_ADVANCE;
                end
            end
            S_ADVANCE: begin
                if ((mbx_q == LAST_X) && (mby_q == LAST_Y)) begin
                    done_pulse = 1'b1;
                    busy_d     = 1'b0;
                    state_d    = S_IDLE;
                end else if (mbx_q == LAST_X) begin
                    mbx_d   = 8'd0;
                    mby_d   = mby_q + 8'd1;
                    state_d = S_LAUNCH;
                end else begin
                    mbx_d   = mbx_q + 8'd1;
                    state_d = S_LAUNCH;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cand_q  <= '0;
            best_q  <= '1;
            mvx_q   <= 6'd0;
            mvy_q   <= 6'd0;
            mbx_q   <= 8'd0;
            mby_q   <= 8'd0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cand_q  <= cand_d;
            best_q  <= best_d;
            mvx_q   <= mvx_d;
            mvy_q   <= mvy_d;
            mbx_q   <= mbx_d;
            mby_q   <= mby_d;
            busy_q  <= busy_d;
        end
    end

    assign bus_io.frame_busy   = busy_q;
    assign bus_io.frame_done   = done_pulse;
    assign bus_io.me_start     = launch;
    assign bus_io.result_valid = (state_q == S_RESULT);
    assign bus_io.mb_x         = mbx_q;
    assign bus_io.mb_y         = mby_q;
    assign bus_io.mv_x         = mvx_q;
    assign bus_io.mv_y         = mvy_q;
    assign bus_io.best_sad     = best_q;

endmodule
`default_nettype wire

// File: tb/tb_me_mb_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_me_mb_scheduler
// Brief    : Randomized bench for me_mb_scheduler on a 3x3-macroblock frame.
// Revision : 1.0
// ============================================================================
module tb_me_mb_scheduler;
    localparam int W    = 3;
    localparam int H    = 3;
    localparam int MD   = 16;
    localparam int P    = 32;
    localparam int HALF = 16;
    localparam int NC   = P * P;

    localparam int PAT_RAND = 0;
    localparam int PAT_OOB  = 1;
    localparam int PAT_TIES = 2;
    localparam int PAT_B    = 3;
    localparam int PAT_C    = 4;
    localparam int PAT_D    = 5;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    me_mb_scheduler_if #(.SAD_W(16)) bus ();

    me_mb_scheduler #(
        .MACRO_DIM (16),
        .SEARCH_DIM(48),
        .FRAME_W_MB(W),
        .FRAME_H_MB(H),
        .SAD_W     (16)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus_io(bus)
    );

    typedef struct {
        int mbx;
        int mby;
        int mvx;
        int mvy;
        int sad;
    } exp_t;

    exp_t expq[$];
    int   n_checks = 0;
    int   n_err    = 0;
    int   n_done   = 0;
    int   scan_dx[NC];
    int   scan_dy[NC];
    int   sads[NC];
    bit   done_exp   = 1'b0;
    bit   prev_start = 1'b0;

    task automatic chk(input string name, input int act, input int req);
        n_checks++;
        if (act != req) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Walk the search window column by column, reversing direction each column.
    function automatic void build_scan();
        int idx = 0;
        for (int c = 0; c < P; c++) begin
            for (int k = 0; k < P; k++) begin
                scan_dx[idx] = c - HALF;
                scan_dy[idx] = (((c % 2) == 0) ? k : (P - 1 - k)) - HALF;
                idx++;
            end
        end
    endfunction

    function automatic int find_cand(input int dx, input int dy);
        for (int i = 0; i < NC; i++) begin
            if (scan_dx[i] == dx && scan_dy[i] == dy) return i;
        end
        return 0;
    endfunction

    // Minimum over in-frame candidates; first in scan order on ties.
    function automatic exp_t model(input int mbx, input int mby);
        exp_t e;
        int   best = 1 << 30;
        e.mbx = mbx; e.mby = mby; e.mvx = 0; e.mvy = 0; e.sad = 0;
        for (int i = 0; i < NC; i++) begin
            int px = mbx * MD + scan_dx[i];
            int py = mby * MD + scan_dy[i];
            if (px >= 0 && px <= (W - 1) * MD && py >= 0 && py <= (H - 1) * MD &&
                sads[i] < best) begin
                best  = sads[i];
                e.mvx = scan_dx[i];
                e.mvy = scan_dy[i];
            end
        end
        e.sad = best;
        return e;
    endfunction

    function automatic void fill(input int pat);
        for (int i = 0; i < NC; i++) begin
            case (pat)
                PAT_RAND, PAT_OOB: sads[i] = int'($urandom_range(0, 60000));
                PAT_TIES:          sads[i] = int'($urandom_range(0, 15));
                default:           sads[i] = 1000;
            endcase
        end
        case (pat)
            PAT_OOB: sads[NC-1] = 0;
            PAT_B:   sads[163] = 37;
            PAT_C:   begin sads[10] = 50; sads[900] = 50; end
            PAT_D:   begin
                sads[find_cand(-1, 0)] = 5;
                sads[find_cand(3, 4)]  = 20;
            end
            default: ;
        endcase
    endfunction

    task automatic chk_reset(input string tag);
        chk({tag, "_busy"},  int'(bus.frame_busy), 0);
        chk({tag, "_done"},  int'(bus.frame_done), 0);
        chk({tag, "_start"}, int'(bus.me_start), 0);
        chk({tag, "_valid"}, int'(bus.result_valid), 0);
        chk({tag, "_mbx"},   int'(bus.mb_x), 0);
        chk({tag, "_mby"},   int'(bus.mb_y), 0);
        chk({tag, "_mvx"},   int'(bus.mv_x), 0);
        chk({tag, "_mvy"},   int'(bus.mv_y), 0);
        chk({tag, "_sad"},   int'(bus.best_sad), 65535);
    endtask

    task automatic start_frame(input bit slow_ready);
        if (slow_ready) bus.me_ready = 1'b0;
        bus.frame_start = 1'b1;
        tick();
        bus.frame_start = 1'b0;
        chk("busy_on_accept", int'(bus.frame_busy), 1);
        if (slow_ready) begin
            repeat (4) begin
                chk("me_start_without_ready", int'(bus.me_start), 0);
                tick();
            end
            bus.me_ready = 1'b1;
            #1;
        end
        chk("me_start_after_accept", int'(bus.me_start), 1);
    endtask

    task automatic run_mb(input int mbx, input int mby, input int pat,
                          input int hold, input bit abort);
        exp_t e;
        int   i;
        int   t;
        bit   last;
        fill(pat);
        e = model(mbx, mby);
        case (pat)
            PAT_B: begin
                chk("pin_B_mvx", e.mvx, -11); chk("pin_B_mvy", e.mvy, 12);
                chk("pin_B_sad", e.sad, 37);
            end
            PAT_C: begin
                chk("pin_C_mvx", e.mvx, -16); chk("pin_C_mvy", e.mvy, -6);
                chk("pin_C_sad", e.sad, 50);
            end
            PAT_D: begin
                chk("pin_D_mvx", e.mvx, 3); chk("pin_D_mvy", e.mvy, 4);
                chk("pin_D_sad", e.sad, 20);
            end
            default: ;
        endcase
        if (!abort) expq.push_back(e);

        t = 0;
        while (!bus.me_start && t < 50) begin
            bus.sad_valid = 1'($urandom % 2);
            bus.sad_in    = 16'd0;
            tick();
            t++;
        end
        if (!bus.me_start) begin
            chk("me_start_timeout", 0, 1);
            return;
        end
        // A zero SAD in the launch cycle must not be counted.
        bus.sad_valid = 1'b1;
        bus.sad_in    = 16'd0;
        tick();

        i = 0;
        while (i < NC) begin
            if (($urandom % 8) == 0) begin
                bus.sad_valid = 1'b0;
                bus.sad_in    = 16'($urandom);
            end else begin
                bus.sad_valid = 1'b1;
                bus.sad_in    = 16'(sads[i]);
                i++;
            end
            tick();
            if (abort && i == 500) begin
                bus.sad_valid = 1'b0;
                rst_n = 1'b0;
                #1;
                chk_reset("midrst");
                tick();
                chk_reset("midrst_hold");
                rst_n = 1'b1;
                tick();
                return;
            end
        end
        bus.sad_valid = 1'b0;
        chk("result_latency", int'(bus.result_valid), 1);
        t = 0;
        while (!bus.result_valid && t < 20) begin
            tick();
            t++;
        end

        repeat (hold) begin
            bus.sad_valid   = 1'($urandom % 2);
            bus.sad_in      = 16'd0;
            bus.frame_start = 1'($urandom % 2);
            tick();
            chk("hold_valid", int'(bus.result_valid), 1);
        end
        bus.frame_start  = 1'b0;
        bus.sad_valid    = 1'b0;
        bus.result_ready = 1'b1;
        tick();
        bus.result_ready = 1'b0;
        last = (mbx == W - 1) && (mby == H - 1);
        chk("advance_valid_low", int'(bus.result_valid), 0);
        tick();
        if (!last) begin
            chk("me_start_2cyc", int'(bus.me_start), 1);
            chk("next_mbx", int'(bus.mb_x), (mbx == W - 1) ? 0 : mbx + 1);
            chk("next_mby", int'(bus.mb_y), (mbx == W - 1) ? mby + 1 : mby);
        end else begin
            chk("busy_after_done", int'(bus.frame_busy), 0);
            chk("idle_no_start", int'(bus.me_start), 0);
        end
    endtask

    // Every cycle: result fields against the expectation queue, frame_done
    // timing, and the me_start rules.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                done_exp   = 1'b0;
                prev_start = 1'b0;
            end else begin
                chk("frame_done", int'(bus.frame_done), int'(done_exp));
                if (bus.frame_done) n_done++;
                done_exp = 1'b0;
                chk("me_start_back_to_back", int'(bus.me_start && prev_start), 0);
                if (bus.result_valid) begin
                    chk("start_during_result", int'(bus.me_start), 0);
                    chk("busy_during_result", int'(bus.frame_busy), 1);
                    if (expq.size() == 0) begin
                        chk("result_queue", 0, 1);
                    end else begin
                        chk("mb_x", int'(bus.mb_x), expq[0].mbx);
                        chk("mb_y", int'(bus.mb_y), expq[0].mby);
                        chk("mv_x", int'($signed(bus.mv_x)), expq[0].mvx);
                        chk("mv_y", int'($signed(bus.mv_y)), expq[0].mvy);
                        chk("best_sad", int'(bus.best_sad), expq[0].sad);
                        if (bus.result_ready) begin
                            if (expq[0].mbx == W - 1 && expq[0].mby == H - 1) done_exp = 1'b1;
                            void'(expq.pop_front());
                        end
                    end
                end
                prev_start = bus.me_start;
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.frame_start  = 1'b0;
        bus.me_ready     = 1'b1;
        bus.sad_valid    = 1'b0;
        bus.sad_in       = 16'd0;
        bus.result_ready = 1'b0;
        build_scan();
        repeat (3) tick();
        chk_reset("reset");
        rst_n = 1'b1;
        tick();

        start_frame(1'b1);
        for (int y = 0; y < H; y++) begin
            for (int x = 0; x < W; x++) begin
                int pat;
                if      (x == 0 && y == 0) pat = PAT_D;
                else if (x == 1 && y == 1) pat = PAT_B;
                else if (x == 2 && y == 0) pat = PAT_OOB;
                else if (x == 0 && y == 1) pat = PAT_TIES;
                else                       pat = PAT_RAND;
                run_mb(x, y, pat, (x == 0 && y == 0) ? 10 : int'($urandom_range(0, 3)), 1'b0);
            end
        end

        tick();
        start_frame(1'b0);
        run_mb(0, 0, PAT_RAND, 0, 1'b1);

        start_frame(1'b0);
        for (int y = 0; y < H; y++) begin
            for (int x = 0; x < W; x++) begin
                int pat;
                if      (x == 1 && y == 1) pat = PAT_C;
                else if (x == 2 && y == 2) pat = PAT_OOB;
                else if (x == 2 && y == 1) pat = PAT_TIES;
                else                       pat = PAT_RAND;
                run_mb(x, y, pat, int'($urandom_range(0, 3)), 1'b0);
            end
        end

        repeat (3) tick();
        chk("frame_done_count", n_done, 2);
        chk("results_outstanding", expq.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end
endmodule
`default_nettype wire
